// File: rtl/note_glyph_pkg.sv
// Shared types for the note glyph streamer: note codes and FSM state encoding.
package note_glyph_pkg;

    localparam int unsigned NOTE_W = 3;

    // Note request codes; REST draws the staff only.
    typedef enum logic [NOTE_W-1:0] {
        NOTE_A    = 3'd0,
        NOTE_B    = 3'd1,
        NOTE_C    = 3'd2,
        NOTE_D    = 3'd3,
        NOTE_E    = 3'd4,
        NOTE_F    = 3'd5,
        NOTE_G    = 3'd6,
        NOTE_REST = 3'd7
    } note_e;

    // Streamer control states.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // True when the note code carries no head (and no stem).
    function automatic logic is_rest(input logic [NOTE_W-1:0] note);
        return note == NOTE_REST;
    endfunction

endpackage

// File: rtl/note_glyph_streamer_row_gen.sv
// Combinational row pattern generator: (row index, note) -> pixel row.
// Optional stem drawing is enabled by defining NOTE_STEM_EN.
module note_row_gen
    import note_glyph_pkg::*;
#(
    parameter int unsigned TILE_W     = 16,
    parameter int unsigned TILE_H     = 16,
    parameter int unsigned LINE_PITCH = 4,
    parameter int unsigned HEAD_COL   = 2,
    parameter int unsigned HEAD_W     = 12
`ifdef NOTE_STEM_EN
    ,
    parameter int unsigned STEM_COL   = 13,
    parameter int unsigned STEM_LEN   = 6
`endif
) (
    input  logic [$clog2(TILE_H)-1:0] row_idx_i,
    input  logic [NOTE_W-1:0]         note_i,
    output logic [TILE_W-1:0]         row_data_c
);

    localparam int unsigned IDX_W = $clog2(TILE_H);
    localparam int unsigned HR_W  = IDX_W + 1;

    logic [TILE_W-1:0] head_mask;
    logic [HR_W-1:0]   hr;
    logic [HR_W-1:0]   row_ext;

    // Constant mask covering the note head columns.
    always_comb begin
        head_mask = '0;
        for (int unsigned c = 0; c < TILE_W; c++) begin
            head_mask[c] = (c >= HEAD_COL) && (c < HEAD_COL + HEAD_W);
        end
    end

    // OR together staff line, head rows and (optionally) the stem.
    always_comb begin
        hr         = HR_W'(TILE_H - 2) - (HR_W'(note_i) << 1);
        row_ext    = HR_W'(row_idx_i);
        row_data_c = '0;
        if ((32'(row_idx_i) % LINE_PITCH) == 32'd0) begin
            row_data_c = '1;
        end
        if (!is_rest(note_i)) begin
            if ((row_ext == hr) || (row_ext == hr + HR_W'(1))) begin
                row_data_c = row_data_c | head_mask;
            end
`ifdef NOTE_STEM_EN
            // Stem spans the STEM_LEN rows above the head, clipped at row 0.
            if ((row_ext < hr) && ((32'(row_ext) + STEM_LEN) >= 32'(hr))) begin
                row_data_c[STEM_COL] = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/note_glyph_streamer.sv
// Note glyph streamer: accepts a note request and emits the glyph bitmap
// one row per handshake. Define NOTE_STEM_EN to draw a stem above the head.
module note_glyph_streamer
    import note_glyph_pkg::*;
#(
    parameter int unsigned TILE_W     = 16,
    parameter int unsigned TILE_H     = 16,
    parameter int unsigned LINE_PITCH = 4,
    parameter int unsigned HEAD_COL   = 2,
    parameter int unsigned HEAD_W     = 12
`ifdef NOTE_STEM_EN
    ,
    parameter int unsigned STEM_COL   = 13,
    parameter int unsigned STEM_LEN   = 6
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [NOTE_W-1:0]         req_note,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [TILE_W-1:0]         row_data,
    output logic [$clog2(TILE_H)-1:0] row_idx,
    output logic                      row_last,
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(TILE_H);

    state_e              state_q,     state_d;
    logic [NOTE_W-1:0]   note_q,      note_d;
    logic                req_ready_q, req_ready_d;
    logic                row_valid_q, row_valid_d;
    logic [TILE_W-1:0]   row_data_q,  row_data_d;
    logic [IDX_W-1:0]    row_idx_q,   row_idx_d;
    logic                row_last_q,  row_last_d;
    logic                busy_q,      busy_d;

    logic [IDX_W-1:0]    gen_idx;
    logic [NOTE_W-1:0]   gen_note;
    logic [TILE_W-1:0]   gen_row_c;

    // Pattern for the row about to be loaded into the output register.
    note_row_gen #(
        .TILE_W     (TILE_W),
        .TILE_H     (TILE_H),
        .LINE_PITCH (LINE_PITCH),
        .HEAD_COL   (HEAD_COL),
        .HEAD_W     (HEAD_W)
`ifdef NOTE_STEM_EN
        ,
        .STEM_COL   (STEM_COL),
        .STEM_LEN   (STEM_LEN)
`endif
    ) u_row_gen (
        .row_idx_i  (gen_idx),
        .note_i     (gen_note),
        .row_data_c (gen_row_c)
    );

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            note_q      <= '0;
            req_ready_q <= 1'b1;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            row_idx_q   <= '0;
            row_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_q      <= note_d;
            req_ready_q <= req_ready_d;
            row_valid_q <= row_valid_d;
            row_data_q  <= row_data_d;
            row_idx_q   <= row_idx_d;
            row_last_q  <= row_last_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: accept a request in IDLE, advance a row per handshake in EMIT.
    always_comb begin
        state_d     = state_q;
        note_d      = note_q;
        req_ready_d = req_ready_q;
        row_valid_d = row_valid_q;
        row_data_d  = row_data_q;
        row_idx_d   = row_idx_q;
        row_last_d  = row_last_q;
        busy_d      = busy_q;
        gen_idx     = '0;
        gen_note    = req_note;

        case (state_q)
            IDLE: begin
                gen_idx  = '0;
                gen_note = req_note;
                if (req_valid && req_ready_q) begin
                    state_d     = EMIT;
                    note_d      = req_note;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    row_valid_d = 1'b1;
                    row_idx_d   = '0;
                    row_data_d  = gen_row_c;
                    row_last_d  = (IDX_W'(TILE_H - 1) == '0);
                end
            end
            EMIT: begin
                gen_idx  = row_idx_q + IDX_W'(1);
                gen_note = note_q;
                if (row_ready) begin
                    if (row_last_q) begin
                        state_d     = IDLE;
                        req_ready_d = 1'b1;
                        busy_d      = 1'b0;
                        row_valid_d = 1'b0;
                        row_data_d  = '0;
                        row_idx_d   = '0;
                        row_last_d  = 1'b0;
                    end else begin
                        row_idx_d   = gen_idx;
                        row_data_d  = gen_row_c;
                        row_last_d  = (gen_idx == IDX_W'(TILE_H - 1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign row_valid = row_valid_q;
    assign row_data  = row_data_q;
    assign row_idx   = row_idx_q;
    assign row_last  = row_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_note_glyph_streamer.sv
// Self-checking bench for note_glyph_streamer (default parameters).
// Define NOTE_STEM_EN for both RTL and bench to cover the stem build.
module tb_note_glyph_streamer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_note;
    logic        row_valid;
    logic        row_ready;
    logic [15:0] row_data;
    logic [3:0]  row_idx;
    logic        row_last;
    logic        busy;

    int          n_tests;
    int          n_fail;
    int          cur_note;
    int          exp_idx;
    logic [15:0] got [16];

    note_glyph_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_note  (req_note),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Glyph rules written directly from the drawing description.
    function automatic logic [15:0] model_row(input int note, input int r);
        logic [15:0] v;
        int hr;
        v = 16'h0000;
        if (r % 4 == 0) v = 16'hFFFF;
        if (note != 7) begin
            hr = 14 - 2 * note;
            if (r == hr || r == hr + 1) begin
                for (int c = 2; c < 14; c++) v[c] = 1'b1;
            end
`ifdef NOTE_STEM_EN
            if (r < hr && r >= hr - 6) v[13] = 1'b1;
`endif
        end
        return v;
    endfunction

    // Expected row index advances on every row handshake.
    always @(posedge clk) begin
        if (!rst_n) exp_idx <= 0;
        else if (row_valid && row_ready) exp_idx <= row_last ? 0 : exp_idx + 1;
    end

    // Continuous compare of every valid row against the model.
    always @(negedge clk) begin
        if (rst_n && row_valid) begin
            chk("row_idx_seq", 32'(row_idx), 32'(exp_idx));
            chk("row_data_model", 32'(row_data), 32'(model_row(cur_note, exp_idx)));
            chk("row_last_model", 32'(row_last), 32'(exp_idx == 15));
            chk("busy_emit", 32'(busy), 32'd1);
            chk("req_ready_emit", 32'(req_ready), 32'd0);
        end
    end

    // Issue one request and collect all rows, optionally stalling at one row.
    task automatic run_glyph(input int note, input int stall_at, input int stall_n);
        int          cyc;
        int          stalls;
        bit          done;
        logic [15:0] snap;
        @(negedge clk);
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        cur_note  = note;
        req_note  = 3'(note);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("latency_row_valid", 32'(row_valid), 32'd1);
        chk("latency_row_idx", 32'(row_idx), 32'd0);
        done   = 1'b0;
        stalls = 0;
        snap   = '0;
        cyc    = 0;
        while (!done && cyc < 100) begin
            if (row_valid && 32'(row_idx) == 32'(stall_at) && stalls < stall_n) begin
                if (stalls == 0) snap = row_data;
                else begin
                    chk("stall_data", 32'(row_data), 32'(snap));
                    chk("stall_idx", 32'(row_idx), 32'(stall_at));
                    chk("stall_valid", 32'(row_valid), 32'd1);
                end
                row_ready = 1'b0;
                stalls++;
            end else begin
                row_ready = 1'b1;
                if (row_valid) begin
                    got[row_idx] = row_data;
                    if (row_last) done = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        row_ready = 1'b1;
        if (!done) chk("glyph_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc;
        n_tests   = 0;
        n_fail    = 0;
        cur_note  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_note  = 3'd0;
        row_ready = 1'b1;
        for (int i = 0; i < 16; i++) got[i] = '0;

        // 1. reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_row_valid", 32'(row_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_row_data", 32'(row_data), 32'd0);
        chk("rst_row_idx", 32'(row_idx), 32'd0);
        chk("rst_row_last", 32'(row_last), 32'd0);

        // 2. note A
        run_glyph(0, -1, 0);
        chk("A_r0", 32'(got[0]), 32'h0000FFFF);
        chk("A_r1", 32'(got[1]), 32'h00000000);
        chk("A_r4", 32'(got[4]), 32'h0000FFFF);
        chk("A_r8", 32'(got[8]), 32'h0000FFFF);
        chk("A_r12", 32'(got[12]), 32'h0000FFFF);
        chk("A_r14", 32'(got[14]), 32'h00003FFC);
        chk("A_r15", 32'(got[15]), 32'h00003FFC);

        // 3. note G then B, back to back
        run_glyph(6, -1, 0);
        chk("G_r2", 32'(got[2]), 32'h00003FFC);
        chk("G_r3", 32'(got[3]), 32'h00003FFC);
        chk("G_r14", 32'(got[14]), 32'h00000000);
        run_glyph(1, -1, 0);
        chk("B_r12", 32'(got[12]), 32'h0000FFFF);
        chk("B_r13", 32'(got[13]), 32'h00003FFC);

        // 4. REST with 5-cycle stall at row 3
        run_glyph(7, 3, 5);
        for (int r = 0; r < 16; r++)
            chk("REST_row", 32'(got[r]), (r % 4 == 0) ? 32'h0000FFFF : 32'h0);

        // 5. reset mid-glyph at row 7
        @(negedge clk);
        cur_note  = 2;
        req_note  = 3'd2;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!(row_valid && row_idx == 4'd7) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach_r7", 32'(row_idx), 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_row_valid", 32'(row_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_quiet", 32'(row_valid), 32'd0);

        // 6. note A again: restart at row 0, stem check
        run_glyph(0, -1, 0);
        chk("A2_r8", 32'(got[8]), 32'h0000FFFF);
        chk("A2_r12", 32'(got[12]), 32'h0000FFFF);
`ifdef NOTE_STEM_EN
        chk("stem_r9", 32'(got[9]), 32'h00002000);
        chk("stem_r10", 32'(got[10]), 32'h00002000);
        chk("stem_r11", 32'(got[11]), 32'h00002000);
        chk("stem_r13", 32'(got[13]), 32'h00002000);
`else
        chk("nostem_r9", 32'(got[9]), 32'h00000000);
        chk("nostem_r13", 32'(got[13]), 32'h00000000);
`endif
        @(negedge clk);
        chk("end_req_ready", 32'(req_ready), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
